// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM (synchronous write, read data one
// cycle after address) between port 0 (datapath, fixed priority) and port 1
// (peripheral/DMA). Port 1 is never passed over more than BURST_MAX times.
//
// Ports:
//   clock, reset             : single clock; synchronous active-low reset
//   req/we/addr/wdata 0|1    : requester inputs, held until the matching ack
//   ack0/ack1                : one-cycle completion pulse
//   rdata0/rdata1            : read data, valid with ack, held until next ack
//   mem_addr/mem_wdata/mem_we: RAM control, mem_rdata: RAM read data
//   busy                     : transaction in flight (ACCESS or RESP)
//   owner                    : port of the current or most recent grant
//   gnt_cnt0/gnt_cnt1        : saturating grant counters
//
// Optional feature: define MEM_ARBITER_STATS_EN to build the grant counters;
// otherwise gnt_cnt0/gnt_cnt1 are tied to zero.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
);

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned GCNT_W   = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  logic                grant_c;
  logic                grant_port_c;
  logic                we_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                in_resp;
  logic                rd_resp0;
  logic                rd_resp1;

  // State and starvation counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Next state and arbitration; starve_cnt counts port-0 wins over a waiting port 1
  always_comb begin
    state_next   = state;
    starve_next  = starve_cnt;
    grant_c      = 1'b0;
    grant_port_c = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_c    = 1'b1;
          state_next = ACCESS;
          if (req0 && req1 && (starve_cnt < STARVE_W'(BURST_MAX))) begin
            grant_port_c = 1'b0;
            starve_next  = starve_cnt + STARVE_W'(1);
          end else if (req0 && !req1) begin
            grant_port_c = 1'b0;
            starve_next  = '0;
          end else begin
            grant_port_c = 1'b1;
            starve_next  = '0;
          end
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction capture on grant, read data capture in RESP
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      owner     <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (grant_c) begin
        owner     <= grant_port_c;
        we_q      <= grant_port_c ? we1 : we0;
        mem_addr  <= grant_port_c ? addr1 : addr0;
        mem_wdata <= grant_port_c ? wdata1 : wdata0;
      end
      if (rd_resp0) rdata0_q <= mem_rdata;
      if (rd_resp1) rdata1_q <= mem_rdata;
    end
  end

  assign in_resp  = (state == RESP);
  assign rd_resp0 = in_resp & ~owner & ~we_q;
  assign rd_resp1 = in_resp & owner & ~we_q;

  // Gating with reset makes a reset-low cycle abort: no write, no ack
  assign mem_we = (state == ACCESS) & we_q & reset;
  assign ack0   = in_resp & ~owner & reset;
  assign ack1   = in_resp & owner & reset;
  assign busy   = (state == ACCESS) | (state == RESP);

  // RAM data is only valid during RESP, so it is forwarded straight through then
  assign rdata0 = (rd_resp0 & reset) ? mem_rdata : rdata0_q;
  assign rdata1 = (rd_resp1 & reset) ? mem_rdata : rdata1_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [GCNT_W-1:0] cnt0_q;
  logic [GCNT_W-1:0] cnt1_q;

  // Saturating per-port grant counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (grant_c) begin
      if (!grant_port_c && (cnt0_q != '1)) cnt0_q <= cnt0_q + GCNT_W'(1);
      if (grant_port_c && (cnt1_q != '1))  cnt1_q <= cnt1_q + GCNT_W'(1);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transaction table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BURST_MAX = 4;

  logic              clock;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, owner;
  logic [15:0]       gnt_cnt0, gnt_cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  // RAM environment
  logic [DATA_W-1:0] ram [256];
  logic              fill;
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int i);
    return {32'h5A000000 | 32'(i), ~32'(i)};
  endfunction

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp_r0;
    logic [63:0] exp_r1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic do_fill();
    @(negedge clock); fill = 1'b1;
    @(negedge clock); fill = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [63:0] d);
    @(negedge clock); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock); pre_we = 1'b0;
  endtask

  // One isolated transaction; checks address timing, write strobe, latency and data
  task automatic run_txn(input vec_t v);
    int we_cnt;
    int we_off;
    bit got;
    we_cnt = 0; we_off = 0; got = 1'b0;
    @(negedge clock);
    if (!v.port) begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clock);
      if (k == 1) chk("tbl_mem_addr", 64'(mem_addr), 64'(v.addr));
      if (mem_we) begin we_cnt++; we_off = k; end
      if (ack0 || ack1) begin
        got = 1'b1;
        chk("tbl_latency", 64'(k), 64'd2);
        chk("tbl_ack_port", 64'(ack1), 64'(v.port));
        chk("tbl_ack_both", 64'(ack0 & ack1), 64'd0);
        chk("tbl_owner", 64'(owner), 64'(v.port));
        chk("tbl_rdata0", rdata0, v.exp_r0);
        chk("tbl_rdata1", rdata1, v.exp_r1);
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    chk("tbl_ack_seen", 64'(got), 64'd1);
    chk("tbl_we_count", 64'(we_cnt), v.we ? 64'd1 : 64'd0);
    if (v.we) chk("tbl_we_cycle", 64'(we_off), 64'd1);
  endtask

  vec_t vecs [9];
  bit   exp_ord [10];

  // Reference model state for the random run
  logic [63:0] ref_mem [256];
  int          free_cyc, ack_at, g_port, now;
  bit          g_we;
  logic [7:0]  g_addr;
  logic [63:0] g_rval;
  int unsigned passed_over;
  int          gc0, gc1;
  logic [63:0] exp_r0, exp_r1;
  bit          e_ack0, e_ack1;
  bit          act [2];
  bit          d_we [2];
  logic [7:0]  d_addr [2];
  logic [63:0] d_data [2];

  initial begin
    int n, last, t0;
    vecs[0] = '{1'b0, 1'b0, 8'h10, 64'h0, 64'hDEAD, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 64'h1234, 64'hDEAD, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 64'h0, 64'hDEAD, 64'h1234};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD, 64'h1234};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 64'h0, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 64'h0, 64'h5A00_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 64'h0123_4567_89AB_CDEF, 64'h5A00_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 64'h0, 64'h5A00_0000_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
    vecs[8] = '{1'b0, 1'b0, 8'h20, 64'h0, 64'h1234, 64'h0123_4567_89AB_CDEF};
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b0; fill = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    idle_inputs();
    do_reset();
    do_fill();
    preload(8'h10, 64'hDEAD);

    // Reset values
    #1;
    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);

    // Directed transaction table
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Both ports held: starvation bound sets the grant order
    do_reset();
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    n = 0; last = 0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      @(negedge clock);
      if (ack0 && ack1) chk("burst_both_acks", 64'd1, 64'd0);
      if (ack0 || ack1) begin
        chk("burst_grant_order", 64'(ack1), 64'(exp_ord[n]));
        if (n > 0) chk("burst_ack_spacing", 64'(int'(cyc) - last), 64'd3);
        last = int'(cyc);
        n++;
        if (n == 10) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("burst_grant_count", 64'(n), 64'd10);
    @(negedge clock);
`ifdef MEM_ARBITER_STATS_EN
    chk("stats_gnt_cnt0", 64'(gnt_cnt0), 64'd8);
    chk("stats_gnt_cnt1", 64'(gnt_cnt1), 64'd2);
`else
    chk("stats_gnt_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("stats_gnt_cnt1", 64'(gnt_cnt1), 64'd0);
`endif

    // Reset during ACCESS aborts a write
    preload(8'h30, 64'h5);
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 64'hBAD0_BAD0;
    @(negedge clock);
    chk("abort_busy_access", 64'(busy), 64'd1);
    chk("abort_we_before", 64'(mem_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_we_gated", 64'(mem_we), 64'd0);
    req0 = 1'b0;
    @(negedge clock);
    chk("abort_ack0", 64'(ack0), 64'd0);
    chk("abort_ack1", 64'(ack1), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("abort_mem_wdata", mem_wdata, 64'd0);
    chk("abort_owner", 64'(owner), 64'd0);
    chk("abort_rdata0", rdata0, 64'd0);
    chk("abort_ram", ram[8'h30], 64'h5);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_no_ack", 64'(ack0 | ack1), 64'd0);
    end

    // Port 1 alone, back-to-back reads
    do_fill();
    @(negedge clock);
    t0 = int'(cyc);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h00;
    n = 0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clock);
      chk("p1_no_ack0", 64'(ack0), 64'd0);
      if (ack1) begin
        chk("p1_ack_time", 64'(int'(cyc) - t0), 64'(2 + 3 * n));
        chk("p1_rdata1", rdata1, pat(n));
        n++;
        addr1 = 8'(n);
        if (n == 4) req1 = 1'b0;
      end
    end
    chk("p1_ack_count", 64'(n), 64'd4);

    // Randomized run against the transaction-level model
    do_reset();
    do_fill();
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    free_cyc = 0; ack_at = -10; g_port = 0; g_we = 1'b0; g_addr = '0; g_rval = '0;
    passed_over = 0; gc0 = 0; gc1 = 0; exp_r0 = '0; exp_r1 = '0;
    act[0] = 1'b0; act[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      now = int'(cyc);
      e_ack0 = (now == ack_at) && (g_port == 0);
      e_ack1 = (now == ack_at) && (g_port == 1);
      if (e_ack0 && !g_we) exp_r0 = g_rval;
      if (e_ack1 && !g_we) exp_r1 = g_rval;
      chk("rnd_ack0", 64'(ack0), 64'(e_ack0));
      chk("rnd_ack1", 64'(ack1), 64'(e_ack1));
      chk("rnd_mem_we", 64'(mem_we), 64'((now == ack_at - 1) && g_we));
      chk("rnd_busy", 64'(busy), 64'((now == ack_at - 1) || (now == ack_at)));
      chk("rnd_rdata0", rdata0, exp_r0);
      chk("rnd_rdata1", rdata1, exp_r1);
      if (now == ack_at - 1) chk("rnd_mem_addr", 64'(mem_addr), 64'(g_addr));

      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && e_ack0) || (p == 1 && e_ack1)) act[p] = 1'b0;
        if (!act[p] && ($urandom_range(0, 99) < 55)) begin
          act[p]    = 1'b1;
          d_we[p]   = 1'($urandom_range(0, 1));
          d_addr[p] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
          d_data[p] = {$urandom, $urandom};
        end
      end
      req0 = act[0]; we0 = d_we[0]; addr0 = d_addr[0]; wdata0 = d_data[0];
      req1 = act[1]; we1 = d_we[1]; addr1 = d_addr[1]; wdata1 = d_data[1];

      // Port 0 wins unless port 1 has already been passed over BURST_MAX times
      if (now >= free_cyc && (act[0] || act[1])) begin
        if (act[0] && act[1]) begin
          if (passed_over < BURST_MAX) begin g_port = 0; passed_over++; end
          else begin g_port = 1; passed_over = 0; end
        end else begin
          g_port = act[1] ? 1 : 0;
          passed_over = 0;
        end
        g_we   = d_we[g_port];
        g_addr = d_addr[g_port];
        if (g_we) ref_mem[g_addr] = d_data[g_port];
        else      g_rval = ref_mem[g_addr];
        if (g_port == 0) gc0++; else gc1++;
        ack_at   = now + 2;
        free_cyc = now + 3;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
`ifdef MEM_ARBITER_STATS_EN
    chk("rnd_gnt_cnt0", 64'(gnt_cnt0), 64'(gc0));
    chk("rnd_gnt_cnt1", 64'(gnt_cnt1), 64'(gc1));
`else
    chk("rnd_gnt_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("rnd_gnt_cnt1", 64'(gnt_cnt1), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x64 data RAM between two requesters: port 0 is the datapath load/store path, port 1 is a peripheral/DMA requester.
- Sits between the requesters and the RAM; owns the RAM address, write-data and write-enable.
- Port 0 has fixed priority. A bounded-starvation counter guarantees port 1 progress.
- RAM contract (decided): synchronous write; read data valid one cycle after the address is presented.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 64, data width
BURST_MAX, 4, max consecutive port-0 grants while port 1 is waiting (range 1..15)

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req0  input  1  port 0 request; held until ack0
we0  input  1  port 0 write (1) / read (0)
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  one-cycle completion pulse, port 0
rdata0  output  DATA_W  port 0 read data, valid with ack0
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_we  output  1  RAM write enable
mem_rdata  input  DATA_W  RAM read data
busy  output  1  high in ACCESS and RESP
owner  output  1  port of the current or most recent grant
gnt_cnt0, gnt_cnt1  output  16  grant counters (see Optional Feature)

Behaviour:
- Reset (reset==0 at an edge) sets:
  - state=IDLE
  - ack0=ack1=0, rdata0=rdata1=0
  - mem_addr=0, mem_wdata=0
  - owner=0, starve_cnt=0
- mem_we = (state==ACCESS) & we_q & reset. It is combinational-gated, so a write never occurs in a cycle where reset is low.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner, register addr/we/wdata into mem_addr/we_q/mem_wdata, set owner, go to ACCESS.
- ACCESS:
  - RAM is addressed; a write commits at the end of this cycle.
  - Always go to RESP.
- RESP:
  - ack of the owner port = 1 for exactly this cycle; the other ack stays 0.
  - For a read, rdata of the owner port = mem_rdata, captured combinationally into a register that holds until the next ack on that port.
  - For a write, rdata of the owner port is unchanged.
  - Always go to IDLE.
- Latency: request sampled in IDLE at cycle t -> ack at t+2. Throughput is one transaction per 3 cycles.
- Requester rule: drop req (or present the next transaction) on the edge after ack. A req seen high in IDLE is always a new transaction.
- Arbitration in IDLE:
  - Only req0: grant 0. Only req1: grant 1.
  - Both requesting and starve_cnt < BURST_MAX: grant 0 and increment starve_cnt.
  - Both requesting and starve_cnt == BURST_MAX: grant 1.
  - Any grant to port 1 clears starve_cnt. A port-0 grant with req1 low also clears starve_cnt.
- Request inputs are ignored outside IDLE. Changing a held request before ack is a protocol violation with undefined result.
- Addresses use the full ADDR_W range with no wrap or remap. Data passes through unmodified.
- Reset low in ACCESS or RESP aborts the transaction:
  - No write, no ack.
  - Next state is IDLE.
  - The requester must re-present the request.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- When defined:
  - gnt_cnt0 and gnt_cnt1 increment on each IDLE->ACCESS grant to their port.
  - Counters saturate at 0xFFFF and clear on reset.
- When undefined:
  - Counter logic is not built; both outputs are tied to 0.
  - Functional behaviour is otherwise identical.

Test Plan:
- RAM[0x10]=0xDEAD; req0 read 0x10 at t -> mem_addr=0x10 at t+1, ack0=1 and rdata0=0xDEAD at t+2, ack1=0, owner=0.
- req1 write 0x20 data 0x1234, then req1 read 0x20 -> mem_we high exactly one cycle, at t+1; second ack1 returns rdata1=0x1234; rdata0 unchanged.
- req0 and req1 held continuously, BURST_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1; acks every 3 cycles; no cycle has both acks high.
- Write from port 0 to 0x30 (old 0x5), reset low during ACCESS -> mem_we=0 that cycle, no ack, RAM[0x30]=0x5, state IDLE, all outputs at reset values.
- req1 alone, back-to-back reads of 0x00..0x03 -> ack1 at t+2, t+5, t+8, t+11; starve_cnt stays 0.
- With MEM_ARBITER_STATS_EN, the third scenario's 10 grants -> gnt_cnt0=8, gnt_cnt1=2. Without the macro -> both 0.
